// File: rtl/serial_sub_if.sv
// Handshake/operand bundle for the bit-serial subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dif_out;
  logic             bor_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a_in, b_in,
                  input  busy, done, dif_out, bor_out, ovf);
  modport slave  (input  start, a_in, b_in,
                  output busy, done, dif_out, bor_out, ovf);
`else
  modport master (output start, a_in, b_in,
                  input  busy, done, dif_out, bor_out);
  modport slave  (input  start, a_in, b_in,
                  output busy, done, dif_out, bor_out);
`endif
endinterface

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor (dif = a - b), LSB first, one bit per clock.
// Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_sub_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] dif_q, dif_d;
  logic             bor_q, bor_d;
`ifdef SERIAL_SUB_OVF_EN
  logic [1:0]       msb_q, msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic x, y, d_bit, brw_next, load;

  // Full-subtractor cell
  always_comb begin
    x        = a_sh_q[0];
    y        = b_sh_q[0];
    d_bit    = x ^ y ^ brw_q;
    brw_next = (~x & y) | (~(x ^ y) & brw_q);
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    dif_d   = dif_q;
    bor_d   = bor_q;
`ifdef SERIAL_SUB_OVF_EN
    msb_d   = msb_q;
    ovf_d   = ovf_q;
`endif
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) load = 1'b1;
      end
      RUN: begin
        res_d  = {d_bit, res_q[WIDTH-1:1]};
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        brw_d  = brw_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIN;
      end
      FIN: begin
        done_d = 1'b1;
        dif_d  = res_q;
        bor_d  = brw_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d  = (msb_q[1] ^ msb_q[0]) & (msb_q[1] ^ res_q[WIDTH-1]);
`endif
        state_d = IDLE;
        if (bus.start) load = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Operand capture shared by IDLE and back-to-back FIN acceptance
    if (load) begin
      a_sh_d  = bus.a_in;
      b_sh_d  = bus.b_in;
      brw_d   = 1'b0;
      cnt_d   = '0;
      state_d = RUN;
`ifdef SERIAL_SUB_OVF_EN
      msb_d   = {bus.a_in[WIDTH-1], bus.b_in[WIDTH-1]};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dif_q   <= '0;
      bor_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      msb_q   <= '0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dif_q   <= dif_d;
      bor_q   <= bor_d;
`ifdef SERIAL_SUB_OVF_EN
      msb_q   <= msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = done_q;
  assign bus.dif_out = dif_q;
  assign bus.bor_out = bor_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf     = ovf_q;
`endif
endmodule
